load_align_unit: RTL and testbench
==================================

# load_align_unit

Memory-stage load unit, the read-side counterpart of the store data packer. It accepts one load request from the core and issues 8-byte-aligned reads to data memory. It extracts the addressed byte, halfword, word or doubleword from the returned 64-bit beat(s) and sign- or zero-extends the result to 64 bits. Misaligned loads that cross an 8-byte boundary take two memory beats. A single request is in flight at a time, and the response is held until the core accepts it.

## Interface
Parameters:
- none; all widths come from CorePack types (data_t = 64 bits, addr_t = 64 bits).

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  mem_op_enum  MEM_B/MEM_H/MEM_W/MEM_D; any other value means no access.
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend; ignored for MEM_D.
- req_addr  in  addr_t  byte address.
- dmem_ren  out  1  read request; held high until dmem_rvalid.
- dmem_raddr  out  addr_t  read address, always {addr[63:3], 3'b0}.
- dmem_rvalid  in  1  read data valid, single-cycle pulse.
- dmem_rdata  in  data_t  little-endian 64-bit beat.
- resp_valid  out  1  result valid.
- resp_ready  in  1  core accepts result.
- resp_data  out  data_t  extended load result.
- resp_err  out  1  misaligned-crossing fault; only present when the macro is absent, otherwise tied to 0.

## Operation
- Request fields are captured on a req_valid & req_ready handshake.
- offset = addr[2:0]. The byte count n is 1, 2, 4 or 8. cross = (offset + n > 8).
- States:
  - IDLE -> RD0 on accept, for a valid op.
  - IDLE -> RESP on accept for a non-load op. resp_data = 0 and no memory access is made.
  - RD0 -> RD1 on dmem_rvalid when cross. RD1 reads aligned address + 8, wrapping modulo 2^64.
  - RD0 -> RESP on dmem_rvalid when not cross.
  - RD1 -> RESP on dmem_rvalid.
  - RESP -> IDLE on resp_ready.
- Extraction:
  - Form the 128-bit value {beat1, beat0}. beat1 = 0 when not cross.
  - Shift it right by offset*8 and keep the low n bytes.
  - Bit 8n-1 is the sign when req_unsigned = 0.
- dmem_rvalid outside RD0/RD1 is ignored.
- resp_data and resp_err are stable while resp_valid is high and resp_ready is low.

## Timing
- Reset values: req_ready = 0 during reset and 1 in IDLE after release. dmem_ren = 0, dmem_raddr = 0, resp_valid = 0, resp_data = 0, resp_err = 0.
- Accept in cycle T -> dmem_ren = 1 in T+1.
- dmem_rvalid in cycle R -> resp_valid = 1 in R+1 (single beat), or dmem_ren for beat 1 in R+1 (crossing).
- Minimum latency for an aligned load with zero-wait memory: accept T, rvalid T+1, resp T+2.
- resp_ready in the same cycle resp_valid rises completes the transfer. req_ready is high the next cycle; there is no back-to-back accept within RESP.
- Reset asserted mid-operation: immediately return to IDLE and clear all outputs. The outstanding read is abandoned, and a later stale dmem_rvalid is ignored.

## Configuration
- MISALIGN_SPLIT_EN defined: crossing loads perform the two-beat sequence above, and resp_err is constant 0.
- MISALIGN_SPLIT_EN undefined:
  - a crossing load goes IDLE -> RESP with no dmem_ren, and resp_err = 1, resp_data = 0;
  - RD1 does not exist;
  - non-crossing misaligned loads still succeed.

## Structure
- CorePack already holds mem_op_enum, data_t and addr_t.
- Add load_state_enum (IDLE, RD0, RD1, RESP) to CorePack so the debug/trace logic can decode it.
- One combinational sub-module, load_extract: inputs {beat1, beat0}, offset, op and unsigned flag; output is the 64-bit extended result. It is unit-testable on its own.

## Test plan
Memory contents for all scenarios: word 0x1000 = 0x8877665544332211, word 0x1008 = 0x00000000AABBCCDD.
- MEM_B signed @0x1003 -> one read of 0x1000, resp_data = 0x0000000000000044, resp at T+2 with zero-wait memory.
- MEM_B @0x1007:
  - signed -> 0xFFFFFFFFFFFFFF88;
  - unsigned -> 0x0000000000000088.
- MEM_W signed @0x1006 with the macro defined -> reads of 0x1000 then 0x1008, resp_data = 0xFFFFFFFFCCDD8877. Without the macro -> no dmem_ren, resp_err = 1, resp_data = 0.
- MEM_D @0x1000 with resp_ready held low for 3 cycles -> resp_valid and resp_data = 0x8877665544332211 stay stable; req_ready returns 1 the cycle after resp_ready rises.
- rstn pulsed low while in RD0, then dmem_rvalid arrives after release -> outputs zero, state IDLE, no resp_valid.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
// CorePack: shared core types for the memory stage (access ops, data/address widths,
// load unit state encoding for debug/trace decode).
package CorePack;

  typedef logic [63:0] data_t;
  typedef logic [63:0] addr_t;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_B    = 3'd1,
    MEM_H    = 3'd2,
    MEM_W    = 3'd3,
    MEM_D    = 3'd4
  } mem_op_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } load_state_enum;

  // Access size in bytes; 0 marks an op that performs no memory access.
  function automatic logic [3:0] op_bytes(input mem_op_enum op);
    case (op)
      MEM_B:   return 4'd1;
      MEM_H:   return 4'd2;
      MEM_W:   return 4'd4;
      MEM_D:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// load_extract: selects the addressed bytes from a {beat1, beat0} pair and
// sign- or zero-extends them to 64 bits. Purely combinational.
module load_extract
  import CorePack::*;
(
  input  logic [127:0] i_beats,
  input  logic [2:0]   i_offset,
  input  mem_op_enum   i_op,
  input  logic         i_unsigned,
  output data_t        o_data
);

  data_t w_window;
  logic  w_sign;

  assign w_window = 64'(i_beats >> {i_offset, 3'b000});

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    o_data = '0;
    w_sign = 1'b0;
    case (i_op)
      MEM_B: begin
        w_sign = ~i_unsigned & w_window[7];
        o_data = {{56{w_sign}}, w_window[7:0]};
      end
      MEM_H: begin
        w_sign = ~i_unsigned & w_window[15];
        o_data = {{48{w_sign}}, w_window[15:0]};
      end
      MEM_W: begin
        w_sign = ~i_unsigned & w_window[31];
        o_data = {{32{w_sign}}, w_window[31:0]};
      end
      MEM_D:   o_data = w_window;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Memory-stage load unit: aligned 64-bit reads, byte extraction and extension.
// Build option MISALIGN_SPLIT_EN: split boundary-crossing loads into two beats instead of faulting.
module load_align_unit
  import CorePack::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  mem_op_enum req_op,
  input  logic       req_unsigned,
  input  addr_t      req_addr,
  output logic       dmem_ren,
  output addr_t      dmem_raddr,
  input  logic       dmem_rvalid,
  input  data_t      dmem_rdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output data_t      resp_data,
  output logic       resp_err
);

  load_state_enum r_state;
  load_state_enum w_next_state;

  logic        r_alive;
  mem_op_enum  r_op;
  logic        r_unsigned;
  logic [2:0]  r_offset;
  addr_t       r_raddr;
  data_t       r_resp_data;
`ifdef MISALIGN_SPLIT_EN
  logic        r_cross;
  data_t       r_beat0;
`else
  logic        r_resp_err;
`endif

  logic         w_accept;
  logic [3:0]   w_bytes;
  logic [3:0]   w_end;
  logic         w_is_load;
  logic         w_cross;
  logic [127:0] w_beats;
  data_t        w_extracted;

  // Offset plus size tops out at 7 + 8 = 15, so four bits hold it without overflow.
  assign w_bytes   = op_bytes(req_op);
  assign w_is_load = (w_bytes != 4'd0);
  assign w_end     = {1'b0, req_addr[2:0]} + w_bytes;
  assign w_cross   = (w_end > 4'd8);

  assign req_ready  = r_alive && (r_state == IDLE);
  assign w_accept   = req_valid && req_ready;
  assign dmem_ren   = (r_state == RD0) || (r_state == RD1);
  assign dmem_raddr = r_raddr;
  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_resp_data;
`ifdef MISALIGN_SPLIT_EN
  assign resp_err   = 1'b0;
  assign w_beats    = (r_state == RD1) ? {dmem_rdata, r_beat0} : {64'd0, dmem_rdata};
`else
  assign resp_err   = r_resp_err;
  assign w_beats    = {64'd0, dmem_rdata};
`endif

  load_extract u_extract (
    .i_beats    (w_beats),
    .i_offset   (r_offset),
    .i_op       (r_op),
    .i_unsigned (r_unsigned),
    .o_data     (w_extracted)
  );

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_is_load) begin
            w_next_state = RESP;
          end else begin
`ifdef MISALIGN_SPLIT_EN
            w_next_state = RD0;
`else
            w_next_state = w_cross ? RESP : RD0;
`endif
          end
        end
      end
      RD0: begin
        if (dmem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
          w_next_state = r_cross ? RD1 : RESP;
`else
          w_next_state = RESP;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      RD1: begin
        if (dmem_rvalid) w_next_state = RESP;
      end
`endif
      RESP: begin
        if (resp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The response registers only load on entry to RESP, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alive     <= 1'b0;
      r_op        <= MEM_NONE;
      r_unsigned  <= 1'b0;
      r_offset    <= 3'd0;
      r_raddr     <= '0;
      r_resp_data <= '0;
`ifdef MISALIGN_SPLIT_EN
      r_cross     <= 1'b0;
      r_beat0     <= '0;
`else
      r_resp_err  <= 1'b0;
`endif
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= req_op;
            r_unsigned <= req_unsigned;
            r_offset   <= req_addr[2:0];
`ifdef MISALIGN_SPLIT_EN
            r_cross    <= w_cross;
`endif
            if (w_next_state == RD0) begin
              r_raddr <= {req_addr[63:3], 3'b000};
            end else begin
              r_resp_data <= '0;
`ifndef MISALIGN_SPLIT_EN
              r_resp_err  <= w_is_load;
`endif
            end
          end
        end
        RD0: begin
          if (dmem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
            if (r_cross) begin
              r_beat0 <= dmem_rdata;
              r_raddr <= r_raddr + 64'd8;
            end else begin
              r_resp_data <= w_extracted;
            end
`else
            r_resp_data <= w_extracted;
            r_resp_err  <= 1'b0;
`endif
          end
        end
`ifdef MISALIGN_SPLIT_EN
        RD1: begin
          if (dmem_rvalid) r_resp_data <= w_extracted;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: table-driven loads against a small memory
// model, plus hand sequences for wait states, backpressure and mid-operation reset.
module tb_load_align_unit;
  import CorePack::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid;
  logic       req_ready;
  mem_op_enum req_op;
  logic       req_unsigned;
  addr_t      req_addr;
  logic       dmem_ren;
  addr_t      dmem_raddr;
  logic       dmem_rvalid;
  data_t      dmem_rdata;
  logic       resp_valid;
  logic       resp_ready;
  data_t      resp_data;
  logic       resp_err;

  logic  auto_rvalid = 1'b0;
  data_t auto_rdata  = '0;
  logic  man_rvalid;
  data_t man_rdata;
  logic  mem_en;
  int    mem_wait;
  addr_t reads[$];

  int n_checks = 0;
  int n_pass   = 0;

  assign dmem_rvalid = auto_rvalid | man_rvalid;
  assign dmem_rdata  = man_rvalid ? man_rdata : auto_rdata;

  always #5 clk = ~clk;

  load_align_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .dmem_ren     (dmem_ren),
    .dmem_raddr   (dmem_raddr),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err)
  );

  function automatic data_t mem_read(input addr_t a);
    case (a)
      64'h0000_0000_0000_1000: return 64'h8877665544332211;
      64'h0000_0000_0000_1008: return 64'h00000000AABBCCDD;
      64'hFFFF_FFFF_FFFF_FFF8: return 64'h0123456789ABCDEF;
      64'h0000_0000_0000_0000: return 64'h1122334455667788;
      default:                 return 64'hDEADBEEF0BADF00D;
    endcase
  endfunction

  // Memory responder: answers a held read after mem_wait cycles with a one-cycle pulse.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      auto_rvalid = 1'b0;
      if (mem_en && dmem_ren) begin
        if (wait_cnt >= mem_wait) begin
          auto_rvalid = 1'b1;
          auto_rdata  = mem_read(dmem_raddr);
          reads.push_back(dmem_raddr);
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  typedef struct {
    string      name;
    mem_op_enum op;
    logic       uns;
    addr_t      addr;
    data_t      exp_data;
    logic       exp_err;
    int         exp_reads;
    addr_t      exp_addr0;
    int         exp_lat;
  } vec_t;

  vec_t vecs[17];

  task automatic issue(input mem_op_enum op, input logic uns, input addr_t addr);
    req_valid    = 1'b1;
    req_op       = op;
    req_unsigned = uns;
    req_addr     = addr;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  task automatic wait_resp(input string name, output int lat);
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      n_checks++;
      $display("FAIL %s.timeout: no resp_valid after %0d cycles", name, lat);
    end
  endtask

  task automatic do_load(input vec_t v, input int wait_states);
    int lat;
    int base;
    check({v.name, ".req_ready"}, 64'(req_ready), 64'(1));
    base = reads.size();
    issue(v.op, v.uns, v.addr);
    wait_resp(v.name, lat);
    if (resp_valid) begin
      check({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat + wait_states));
      check({v.name, ".data"}, resp_data, v.exp_data);
      check({v.name, ".err"}, 64'(resp_err), 64'(v.exp_err));
      check({v.name, ".reads"}, 64'(reads.size() - base), 64'(v.exp_reads));
      if (v.exp_reads > 0 && reads.size() > base)
        check({v.name, ".addr0"}, reads[base], v.exp_addr0);
      if (v.exp_reads > 1 && reads.size() > base + 1)
        check({v.name, ".addr1"}, reads[base+1], v.exp_addr0 + 64'd8);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({v.name, ".resp_done"}, 64'(resp_valid), 64'(0));
  endtask

  initial begin
    int lat;
    rstn = 1'b1; req_valid = 1'b0; req_op = MEM_NONE; req_unsigned = 1'b0; req_addr = '0;
    resp_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0; mem_en = 1'b1; mem_wait = 0;

    vecs[0]  = '{"b_s_1003", MEM_B, 1'b0, 64'h1003, 64'h0000000000000044, 1'b0, 1, 64'h1000, 2};
    vecs[1]  = '{"b_s_1007", MEM_B, 1'b0, 64'h1007, 64'hFFFFFFFFFFFFFF88, 1'b0, 1, 64'h1000, 2};
    vecs[2]  = '{"b_u_1007", MEM_B, 1'b1, 64'h1007, 64'h0000000000000088, 1'b0, 1, 64'h1000, 2};
    vecs[3]  = '{"h_s_1002", MEM_H, 1'b0, 64'h1002, 64'h0000000000004433, 1'b0, 1, 64'h1000, 2};
    vecs[4]  = '{"h_s_1006", MEM_H, 1'b0, 64'h1006, 64'hFFFFFFFFFFFF8877, 1'b0, 1, 64'h1000, 2};
    vecs[5]  = '{"w_u_1004", MEM_W, 1'b1, 64'h1004, 64'h0000000088776655, 1'b0, 1, 64'h1000, 2};
    vecs[6]  = '{"w_s_1004", MEM_W, 1'b0, 64'h1004, 64'hFFFFFFFF88776655, 1'b0, 1, 64'h1000, 2};
    vecs[7]  = '{"d_1000",   MEM_D, 1'b0, 64'h1000, 64'h8877665544332211, 1'b0, 1, 64'h1000, 2};
    vecs[8]  = '{"d_u_1008", MEM_D, 1'b1, 64'h1008, 64'h00000000AABBCCDD, 1'b0, 1, 64'h1008, 2};
    vecs[9]  = '{"b_u_1008", MEM_B, 1'b1, 64'h1008, 64'h00000000000000DD, 1'b0, 1, 64'h1008, 2};
    vecs[10] = '{"b_s_1008", MEM_B, 1'b0, 64'h1008, 64'hFFFFFFFFFFFFFFDD, 1'b0, 1, 64'h1008, 2};
    vecs[11] = '{"w_s_100c", MEM_W, 1'b0, 64'h100C, 64'h0000000000000000, 1'b0, 1, 64'h1008, 2};
    vecs[12] = '{"none_op",  MEM_NONE, 1'b0, 64'h1000, 64'h0, 1'b0, 0, 64'h0, 1};
    vecs[13] = '{"bad_op7",  mem_op_enum'(3'd7), 1'b0, 64'h1003, 64'h0, 1'b0, 0, 64'h0, 1};
`ifdef MISALIGN_SPLIT_EN
    vecs[14] = '{"w_s_1006x", MEM_W, 1'b0, 64'h1006, 64'hFFFFFFFFCCDD8877, 1'b0, 2, 64'h1000, 3};
    vecs[15] = '{"h_s_1007x", MEM_H, 1'b0, 64'h1007, 64'hFFFFFFFFFFFFDD88, 1'b0, 2, 64'h1000, 3};
    vecs[16] = '{"h_u_wrap",  MEM_H, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000008801, 1'b0, 2,
                 64'hFFFFFFFFFFFFFFF8, 3};
`else
    vecs[14] = '{"w_s_1006x", MEM_W, 1'b0, 64'h1006, 64'h0, 1'b1, 0, 64'h0, 1};
    vecs[15] = '{"h_s_1007x", MEM_H, 1'b0, 64'h1007, 64'h0, 1'b1, 0, 64'h0, 1};
    vecs[16] = '{"h_u_wrap",  MEM_H, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 0, 64'h0, 1};
`endif

    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.req_ready",  64'(req_ready),  64'(0));
    check("rst.dmem_ren",   64'(dmem_ren),   64'(0));
    check("rst.dmem_raddr", dmem_raddr,      64'(0));
    check("rst.resp_valid", 64'(resp_valid), 64'(0));
    check("rst.resp_data",  resp_data,       64'(0));
    check("rst.resp_err",   64'(resp_err),   64'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("rel.req_ready", 64'(req_ready), 64'(1));

    for (int i = 0; i < 17; i++) do_load(vecs[i], 0);

    // Slow memory: dmem_ren must be held until the delayed rvalid.
    mem_wait = 2;
    do_load(vecs[0], 2);
    mem_wait = 0;

    // Backpressure: response held for three cycles with resp_ready low.
    issue(MEM_D, 1'b0, 64'h1000);
    wait_resp("bp", lat);
    for (int i = 0; i < 3; i++) begin
      check("bp.resp_valid", 64'(resp_valid), 64'(1));
      check("bp.resp_data",  resp_data,       64'h8877665544332211);
      check("bp.req_ready",  64'(req_ready),  64'(0));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp.req_ready_after", 64'(req_ready),  64'(1));
    check("bp.resp_valid_after", 64'(resp_valid), 64'(0));

    // Reset while RD0 is waiting, then a stale rvalid after release.
    mem_en = 1'b0;
    issue(MEM_B, 1'b0, 64'h1003);
    check("mrst.ren_before",   64'(dmem_ren), 64'(1));
    check("mrst.raddr_before", dmem_raddr,    64'h1000);
    rstn = 1'b0;
    #1;
    check("mrst.dmem_ren",   64'(dmem_ren),   64'(0));
    check("mrst.dmem_raddr", dmem_raddr,      64'(0));
    check("mrst.resp_valid", 64'(resp_valid), 64'(0));
    check("mrst.resp_data",  resp_data,       64'(0));
    check("mrst.resp_err",   64'(resp_err),   64'(0));
    check("mrst.req_ready",  64'(req_ready),  64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    man_rvalid = 1'b1;
    man_rdata  = 64'h8877665544332211;
    @(negedge clk);
    man_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale.resp_valid", 64'(resp_valid),  64'(0));
      check("stale.dmem_ren",   64'(dmem_ren),    64'(0));
      check("stale.state",      64'(dut.r_state), 64'(IDLE));
      check("stale.resp_data",  resp_data,        64'(0));
      @(negedge clk);
    end
    mem_en = 1'b1;
    do_load(vecs[4], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
